// File: rtl/multiport_register_file.sv
// Decode-stage register file: NRD combinational read ports, NWR write ports,
// optional same-cycle write bypass, and a one-bit-per-register pending-write scoreboard.
module multiport_register_file #(
    parameter  int WIDTH  = 32,
    parameter  int NREGS  = 32,
    parameter  int NRD    = 2,
    parameter  int NWR    = 1,
    parameter  int BYPASS = 1,
    localparam int SELW   = $clog2(NREGS)
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic [NWR-1:0]       WEN,
    input  logic [NWR*SELW-1:0]  wsel,
    input  logic [NWR*WIDTH-1:0] wdat,
    input  logic [NRD*SELW-1:0]  rsel,
    output logic [NRD*WIDTH-1:0] rdat,
    output logic [NRD-1:0]       rbusy,
    input  logic                 rsv_en,
    input  logic [SELW-1:0]      rsv_sel,
    input  logic                 flush,
    output logic [NREGS-1:0]     busy_vec
);

    logic [WIDTH-1:0] r_mem [NREGS];
    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_nxt;
    logic [NREGS-1:0] w_wr_hit;
    logic [SELW-1:0]  w_rsel;

    // Entry 0 is never written after reset, so it stays zero.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            // Ascending port order: the last non-blocking assignment, i.e. the highest port, wins.
            for (int p = 0; p < NWR; p++) begin
                if (WEN[p] && (wsel[p*SELW +: SELW] != '0)) begin
                    r_mem[wsel[p*SELW +: SELW]] <= wdat[p*WIDTH +: WIDTH];
                end
            end
        end
    end

    always_comb begin
        w_wr_hit = '0;
        for (int p = 0; p < NWR; p++) begin
            if (WEN[p]) begin
                w_wr_hit[wsel[p*SELW +: SELW]] = 1'b1;
            end
        end
        w_wr_hit[0] = 1'b0;
    end

    // Flush beats a reservation, and a reservation beats a completing write.
    always_comb begin
        w_busy_nxt = '0;
        if (!flush) begin
            for (int i = 1; i < NREGS; i++) begin
                if (rsv_en && (rsv_sel == SELW'(i))) begin
                    w_busy_nxt[i] = 1'b1;
                end else if (w_wr_hit[i]) begin
                    w_busy_nxt[i] = 1'b0;
                end else begin
                    w_busy_nxt[i] = r_busy[i];
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign busy_vec = r_busy;

    always_comb begin
        rdat   = '0;
        rbusy  = '0;
        w_rsel = '0;
        for (int r = 0; r < NRD; r++) begin
            w_rsel = rsel[r*SELW +: SELW];
            if (w_rsel != '0) begin
                rdat[r*WIDTH +: WIDTH] = r_mem[w_rsel];
                rbusy[r]               = r_busy[w_rsel];
                if (BYPASS != 0) begin
                    // Forwarded data is valid now, so the pending mark no longer applies.
                    for (int p = 0; p < NWR; p++) begin
                        if (WEN[p] && (wsel[p*SELW +: SELW] == w_rsel)) begin
                            rdat[r*WIDTH +: WIDTH] = wdat[p*WIDTH +: WIDTH];
                            rbusy[r]               = 1'b0;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_multiport_register_file.sv
// Scoreboard bench: stimulus pushes expected values, a negedge monitor pops and compares.
// Two instances share stimulus: u_dut (BYPASS=1) and u_nb (BYPASS=0).
module tb_multiport_register_file;

    localparam int W = 32;
    localparam int S = 5;

    logic          CLK = 1'b0;
    logic          nRST;
    logic [1:0]    WEN;
    logic [2*S-1:0] wsel;
    logic [2*W-1:0] wdat;
    logic [2*S-1:0] rsel;
    logic          rsv_en;
    logic [S-1:0]  rsv_sel;
    logic          flush;
    logic [2*W-1:0] rdat, nb_rdat;
    logic [1:0]    rbusy, nb_rbusy;
    logic [31:0]   busy_vec, nb_busy_vec;

    multiport_register_file #(.WIDTH(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1)) u_dut (
        .CLK(CLK), .nRST(nRST), .WEN(WEN), .wsel(wsel), .wdat(wdat), .rsel(rsel),
        .rdat(rdat), .rbusy(rbusy), .rsv_en(rsv_en), .rsv_sel(rsv_sel), .flush(flush),
        .busy_vec(busy_vec)
    );

    multiport_register_file #(.WIDTH(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(0)) u_nb (
        .CLK(CLK), .nRST(nRST), .WEN(WEN), .wsel(wsel), .wdat(wdat), .rsel(rsel),
        .rdat(nb_rdat), .rbusy(nb_rbusy), .rsv_en(rsv_en), .rsv_sel(rsv_sel), .flush(flush),
        .busy_vec(nb_busy_vec)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          kind;
        int          port;
        logic [31:0] exp;
        string       name;
    } chk_t;

    chk_t q[$];
    int   n_err    = 0;
    int   n_checks = 0;

    logic [31:0] m_mem [32];
    logic [31:0] m_busy;

    function automatic logic [31:0] actual(input int kind, input int port);
        case (kind)
            0:       return rdat[port*W +: W];
            1:       return {31'b0, rbusy[port]};
            2:       return busy_vec;
            3:       return nb_rdat[port*W +: W];
            4:       return {31'b0, nb_rbusy[port]};
            default: return 32'hxxxx_xxxx;
        endcase
    endfunction

    task automatic push(input int kind, input int port, input logic [31:0] exp, input string name);
        chk_t c;
        c.kind = kind; c.port = port; c.exp = exp; c.name = name;
        q.push_back(c);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        WEN = 2'b00; rsv_en = 1'b0; flush = 1'b0;
    endtask

    task automatic set_wr(input int p, input logic [S-1:0] sel, input logic [W-1:0] d);
        WEN[p]          = 1'b1;
        wsel[p*S +: S]  = sel;
        wdat[p*W +: W]  = d;
    endtask

    initial begin : monitor
        chk_t        c;
        logic [31:0] a;
        forever begin
            @(negedge CLK);
            while (q.size() > 0) begin
                c = q.pop_front();
                a = actual(c.kind, c.port);
                n_checks++;
                if (a !== c.exp) begin
                    n_err++;
                    $display("FAIL %s: got %h expected %h", c.name, a, c.exp);
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [1:0]  we;
        logic [4:0]  ws [2];
        logic [31:0] wd [2];
        logic [4:0]  rs [2];
        logic [31:0] ed, eb;
        logic        rv, fl;
        logic [4:0]  rvs;
        logic        hit;

        nRST = 1'b0; idle(); wsel = '0; wdat = '0; rsel = '0; rsv_sel = '0;

        // reset: every register on both ports reads 0, nothing busy
        for (int k = 0; k < 32; k++) begin
            step();
            rsel = {5'(31 - k), 5'(k)};
            push(0, 0, 32'h0, "reset_rdat0");
            push(0, 1, 32'h0, "reset_rdat1");
            push(1, 0, 32'h0, "reset_rbusy0");
            push(1, 1, 32'h0, "reset_rbusy1");
            push(2, 0, 32'h0, "reset_busy_vec");
        end
        step(); nRST = 1'b1;
        step(); rsel = {5'd17, 5'd3};
        push(0, 0, 32'h0, "post_reset_rdat0");
        push(0, 1, 32'h0, "post_reset_rdat1");

        // write/read with bypass
        step(); set_wr(0, 5'd5, 32'hDEADBEEF); rsel = {5'd0, 5'd5};
        push(0, 0, 32'hDEADBEEF, "bypass_rdat");
        push(3, 0, 32'h0,        "nobypass_old_rdat");
        step(); idle();
        push(0, 0, 32'hDEADBEEF, "stored_rdat");
        push(3, 0, 32'hDEADBEEF, "nobypass_stored_rdat");

        // register 0 and write-port priority
        step(); set_wr(0, 5'd0, 32'h1234); rsel = {5'd0, 5'd0};
        push(0, 0, 32'h0, "r0_write_bypass");
        push(0, 1, 32'h0, "r0_write_bypass1");
        step(); idle();
        push(0, 0, 32'h0, "r0_after_write");
        step(); set_wr(0, 5'd7, 32'hAAAA); set_wr(1, 5'd7, 32'hBBBB); rsel = {5'd0, 5'd7};
        push(0, 0, 32'hBBBB, "prio_bypass");
        step(); idle();
        push(0, 0, 32'hBBBB, "prio_stored");
        push(3, 0, 32'hBBBB, "prio_stored_nb");

        // scoreboard: reserve 9, then complete it with a write
        step(); rsv_en = 1'b1; rsv_sel = 5'd9; rsel = {5'd0, 5'd9};
        push(1, 0, 32'h0, "rbusy_before_rsv_edge");
        step(); idle();
        push(2, 0, 32'h0000_0200, "busy_vec_rsv9");
        push(1, 0, 32'h1,         "rbusy_rsv9");
        push(4, 0, 32'h1,         "rbusy_rsv9_nb");
        step(); set_wr(0, 5'd9, 32'h42);
        push(1, 0, 32'h0,         "rbusy_bypassed");
        push(4, 0, 32'h1,         "rbusy_not_suppressed_nb");
        push(0, 0, 32'h42,        "rdat_write9");
        push(2, 0, 32'h0000_0200, "busy_vec_before_edge");
        step(); idle();
        push(2, 0, 32'h0,  "busy_vec_cleared9");
        push(0, 0, 32'h42, "rdat_stored9");
        step(); rsv_en = 1'b1; rsv_sel = 5'd0;
        step(); idle();
        push(2, 0, 32'h0, "rsv_r0_ignored");

        // collisions: reserve+write same reg, then flush beats reserve
        step(); rsv_en = 1'b1; rsv_sel = 5'd3; set_wr(0, 5'd3, 32'h33);
        step(); idle(); rsel = {5'd0, 5'd3};
        push(2, 0, 32'h0000_0008, "rsv_beats_write_busy");
        push(0, 0, 32'h33,        "rsv_write_data");
        push(1, 0, 32'h1,         "rsv_write_rbusy");
        step(); flush = 1'b1; rsv_en = 1'b1; rsv_sel = 5'd4;
        step(); idle();
        push(2, 0, 32'h0, "flush_busy_vec");

        // no-bypass build: old value this cycle, new value next
        step(); set_wr(0, 5'd6, 32'h77); rsel = {5'd6, 5'd0};
        push(3, 1, 32'h0,  "nb_old_rdat6");
        push(0, 1, 32'h77, "bp_new_rdat6");
        step(); idle();
        push(3, 1, 32'h77, "nb_new_rdat6");

        // randomised traffic against a reference model, from a clean reset
        step(); nRST = 1'b0;
        step(); nRST = 1'b1;
        for (int i = 0; i < 32; i++) m_mem[i] = '0;
        m_busy = '0;
        for (int n = 0; n < 40; n++) begin
            step();
            we = 2'($urandom_range(0, 3));
            for (int p = 0; p < 2; p++) begin
                ws[p] = 5'($urandom_range(0, 7));
                wd[p] = $urandom;
                rs[p] = 5'($urandom_range(0, 7));
            end
            rv  = 1'($urandom_range(0, 1));
            rvs = 5'($urandom_range(0, 7));
            fl  = ($urandom_range(0, 7) == 0);
            WEN = we; wsel = {ws[1], ws[0]}; wdat = {wd[1], wd[0]};
            rsel = {rs[1], rs[0]}; rsv_en = rv; rsv_sel = rvs; flush = fl;
            for (int r = 0; r < 2; r++) begin
                ed = 32'h0; eb = 32'h0;
                if (rs[r] != 5'd0) begin
                    ed = m_mem[rs[r]];
                    eb = {31'b0, m_busy[rs[r]]};
                    for (int p = 0; p < 2; p++) begin
                        if (we[p] && ws[p] == rs[r]) begin
                            ed = wd[p]; eb = 32'h0;
                        end
                    end
                end
                push(0, r, ed, "rand_rdat");
                push(1, r, eb, "rand_rbusy");
            end
            push(2, 0, m_busy, "rand_busy_vec");
            for (int i = 1; i < 32; i++) begin
                hit = 1'b0;
                for (int p = 0; p < 2; p++) if (we[p] && ws[p] == 5'(i)) hit = 1'b1;
                if (fl) m_busy[i] = 1'b0;
                else if (rv && rvs == 5'(i)) m_busy[i] = 1'b1;
                else if (hit) m_busy[i] = 1'b0;
            end
            for (int p = 0; p < 2; p++) if (we[p] && ws[p] != 5'd0) m_mem[ws[p]] = wd[p];
        end

        // async reset mid-burst clears array and busy without a clock edge
        step(); idle(); set_wr(0, 5'd6, 32'hCAFE); rsv_en = 1'b1; rsv_sel = 5'd5;
        step(); idle(); rsel = {5'd5, 5'd6};
        push(0, 0, 32'hCAFE, "pre_reset_rdat6");
        push(1, 1, 32'h1,    "pre_reset_rbusy5");
        step(); set_wr(0, 5'd10, 32'h1); set_wr(1, 5'd11, 32'h2);
        #1; nRST = 1'b0; idle();
        push(0, 0, 32'h0, "async_reset_rdat6");
        push(1, 1, 32'h0, "async_reset_rbusy5");
        push(2, 0, 32'h0, "async_reset_busy_vec");
        step(); nRST = 1'b1;
        step();
        push(0, 0, 32'h0, "after_reset_rdat6");
        push(2, 0, 32'h0, "after_reset_busy_vec");

        step(); step();
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL queue_drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
